// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control path.
// Holds the ISA opcode constants, the multi-cycle FSM state encodings,
// the ALUOp function codes and the bundle of static (per-opcode) controls.
// Shared by the single-cycle control unit, the ALU and multi_cycle_control.
package cpu_pkg;

    // ISA opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    // Multi-cycle sequencer states; encodings are visible on the debug port
    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_e;

    // Controls that depend only on the opcode, not on the phase
    typedef struct packed {
        logic       alusrcb;
        logic       extsel;
        logic       regout;
        logic [2:0] aluop;
    } static_ctl_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational opcode decoder.
//   i_op       : opcode to classify
//   o_ctl      : static controls {ALUSrcB, ExtSel, RegOut, ALUOp}
//   o_is_alu   : register-writing ALU op (add/addi/sub/ori/and/or/move)
//   o_is_mem   : lw or sw
//   o_is_lw/o_is_sw/o_is_beq/o_is_halt : single-opcode flags
//   o_is_valid : opcode belongs to the ISA (halt included)
module mc_decode
    import cpu_pkg::*;
(
    input  logic [5:0]  i_op,
    output static_ctl_t o_ctl,
    output logic        o_is_alu,
    output logic        o_is_mem,
    output logic        o_is_lw,
    output logic        o_is_sw,
    output logic        o_is_beq,
    output logic        o_is_halt,
    output logic        o_is_valid
);

    always_comb begin
        o_ctl      = '0;
        o_is_alu   = 1'b0;
        o_is_lw    = 1'b0;
        o_is_sw    = 1'b0;
        o_is_beq   = 1'b0;
        o_is_halt  = 1'b0;
        o_is_valid = 1'b1;
        case (i_op)
            OP_ADD: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b0, regout: 1'b1, aluop: ALU_ADD};
                o_is_alu = 1'b1;
            end
            OP_ADDI: begin
                o_ctl    = '{alusrcb: 1'b1, extsel: 1'b1, regout: 1'b0, aluop: ALU_ADD};
                o_is_alu = 1'b1;
            end
            OP_SUB: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b0, regout: 1'b1, aluop: ALU_SUB};
                o_is_alu = 1'b1;
            end
            OP_ORI: begin
                o_ctl    = '{alusrcb: 1'b1, extsel: 1'b0, regout: 1'b0, aluop: ALU_OR};
                o_is_alu = 1'b1;
            end
            OP_AND: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b0, regout: 1'b1, aluop: ALU_AND};
                o_is_alu = 1'b1;
            end
            OP_OR: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b0, regout: 1'b1, aluop: ALU_OR};
                o_is_alu = 1'b1;
            end
            OP_MOVE: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b0, regout: 1'b1, aluop: ALU_ADD};
                o_is_alu = 1'b1;
            end
            OP_SW: begin
                o_ctl   = '{alusrcb: 1'b1, extsel: 1'b1, regout: 1'b0, aluop: ALU_ADD};
                o_is_sw = 1'b1;
            end
            OP_LW: begin
                o_ctl   = '{alusrcb: 1'b1, extsel: 1'b1, regout: 1'b0, aluop: ALU_ADD};
                o_is_lw = 1'b1;
            end
            OP_BEQ: begin
                o_ctl    = '{alusrcb: 1'b0, extsel: 1'b1, regout: 1'b0, aluop: ALU_SUB};
                o_is_beq = 1'b1;
            end
            OP_HALT: o_is_halt  = 1'b1;
            default: o_is_valid = 1'b0;
        endcase
    end

    assign o_is_mem = o_is_lw | o_is_sw;

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: IF/ID/EXE/MEM/WB sequencer for the CPU datapath.
// Steps each instruction through its phases and drives the datapath
// control set only in the phase that needs each signal.
//   CLK, Reset      : clock and asynchronous active-high reset (back to IF)
//   op, zero        : opcode (valid from ID) and ALU zero flag (used in EXE)
//   PCWre..ALUOp    : datapath controls, combinational from State/op_q
//   State, Halted   : debug state and halt indication (registered)
//   RetireCnt       : retired-instruction counter, wraps at 2^CNT_W
module multi_cycle_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             PCWre,
    output logic             PCSrc,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ALUSrcB,
    output logic             ALUM2Reg,
    output logic             RegWre,
    output logic             DataMemRW,
    output logic             ExtSel,
    output logic             RegOut,
    output logic [2:0]       ALUOp,
    output logic [2:0]       State,
    output logic             Halted,
    output logic [CNT_W-1:0] RetireCnt
);

    state_e           r_state;
    logic [5:0]       r_op_q;
    logic             r_halted;
    logic [CNT_W-1:0] r_cnt;

    state_e      w_next;
    logic [5:0]  w_dec_op;
    static_ctl_t w_ctl;
    logic        w_is_alu, w_is_mem, w_is_lw, w_is_sw;
    logic        w_is_beq, w_is_halt, w_is_valid;

    // One decoder serves both uses: in ID it classifies the live opcode to
    // pick the next state; from EXE on it decodes the captured op_q. Static
    // controls are gated off in ID, so the live-op decode never leaks out.
    assign w_dec_op = (r_state == ST_ID) ? op : r_op_q;

    mc_decode u_dec (
        .i_op       (w_dec_op),
        .o_ctl      (w_ctl),
        .o_is_alu   (w_is_alu),
        .o_is_mem   (w_is_mem),
        .o_is_lw    (w_is_lw),
        .o_is_sw    (w_is_sw),
        .o_is_beq   (w_is_beq),
        .o_is_halt  (w_is_halt),
        .o_is_valid (w_is_valid)
    );

    // Next state and phase-dependent controls
    always_comb begin
        w_next    = r_state;
        PCWre     = 1'b0;
        PCSrc     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUM2Reg  = 1'b0;
        RegWre    = 1'b0;
        DataMemRW = 1'b0;
        case (r_state)
            ST_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                w_next   = ST_ID;
            end
            ST_ID: begin
                if (w_is_halt) begin
                    w_next = ST_HALT;
                end else if (w_is_valid) begin
                    w_next = ST_EXE;
                end else begin
                    // unknown opcode retires as a nop
                    w_next = ST_IF;
                    PCWre  = 1'b1;
                end
            end
            ST_EXE: begin
                if (w_is_alu) begin
                    w_next = ST_WB;
                end else if (w_is_mem) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_IF;
                    PCWre  = w_is_beq;
                    PCSrc  = w_is_beq & zero;
                end
            end
            ST_MEM: begin
                if (w_is_lw) begin
                    w_next   = ST_WB;
                    ALUM2Reg = 1'b1;
                end else begin
                    w_next    = ST_IF;
                    DataMemRW = w_is_sw;
                    PCWre     = 1'b1;
                end
            end
            ST_WB: begin
                w_next   = ST_IF;
                RegWre   = 1'b1;
                PCWre    = 1'b1;
                ALUM2Reg = w_is_lw;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IF;
        endcase
    end

    // Static controls hold for the whole execute part of the instruction
    always_comb begin
        ALUSrcB = 1'b0;
        ExtSel  = 1'b0;
        RegOut  = 1'b0;
        ALUOp   = 3'b000;
        if (r_state == ST_EXE || r_state == ST_MEM || r_state == ST_WB) begin
            ALUSrcB = w_ctl.alusrcb;
            ExtSel  = w_ctl.extsel;
            RegOut  = w_ctl.regout;
            ALUOp   = w_ctl.aluop;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IF;
            r_op_q   <= '0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_ID && w_next == ST_EXE)
                r_op_q <= op;
            if (w_next == ST_HALT)
                r_halted <= 1'b1;
            if (PCWre)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign State     = r_state;
    assign Halted    = r_halted;
    assign RetireCnt = r_cnt;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: random per-instruction stimulus against a
// phase-list reference model of the sequencer.
module tb_multi_cycle_control;

    localparam int CW = 4;
    localparam int VW = 17 + CW;

    localparam logic [5:0] ADD  = 6'b000000, ADDI = 6'b000001, SUB  = 6'b000010;
    localparam logic [5:0] ORI  = 6'b010000, ANDO = 6'b010001, ORO  = 6'b010010;
    localparam logic [5:0] MOVE = 6'b100000, SW   = 6'b100110, LW   = 6'b100111;
    localparam logic [5:0] BEQ  = 6'b110000, HALT = 6'b111111, BAD  = 6'b000111;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic [5:0]    op = '0;
    logic          zero = 1'b0;
    logic          PCWre, PCSrc, IRWre, InsMemRW, ALUSrcB, ALUM2Reg;
    logic          RegWre, DataMemRW, ExtSel, RegOut, Halted;
    logic [2:0]    ALUOp, State;
    logic [CW-1:0] RetireCnt;

    int vecs = 0;
    int errs = 0;
    int exp_cnt = 0;

    multi_cycle_control #(.CNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .RegWre(RegWre),
        .DataMemRW(DataMemRW), .ExtSel(ExtSel), .RegOut(RegOut),
        .ALUOp(ALUOp), .State(State), .Halted(Halted), .RetireCnt(RetireCnt)
    );

    always #5 CLK = ~CLK;

    // {ALUSrcB, ExtSel, RegOut, ALUOp} from the opcode table
    function automatic logic [5:0] stat_of(input logic [5:0] o);
        case (o)
            ADD, MOVE: return 6'b001_000;
            ADDI:      return 6'b110_000;
            SUB:       return 6'b001_001;
            ORI:       return 6'b100_011;
            ANDO:      return 6'b001_100;
            ORO:       return 6'b001_011;
            SW, LW:    return 6'b110_000;
            BEQ:       return 6'b010_001;
            default:   return 6'b000_000;
        endcase
    endfunction

    // cycles per instruction; halt never retires so it gets a length no run reaches
    function automatic int ncyc(input logic [5:0] o);
        case (o)
            ADD, ADDI, SUB, ORI, ANDO, ORO, MOVE, SW: return 4;
            LW:      return 5;
            BEQ:     return 3;
            HALT:    return 99;
            default: return 2;
        endcase
    endfunction

    // state visited in cycle k of an instruction
    function automatic logic [2:0] st_of(input logic [5:0] o, input int k);
        case (k)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return (o == LW || o == SW) ? 3'b011 : 3'b100;
            default: return 3'b100;
        endcase
    endfunction

    // expected output vector for one cycle, from the phase rules
    function automatic logic [VW-1:0] model(input logic [2:0] st, input logic [5:0] o,
                                            input logic z, input logic last,
                                            input logic [CW-1:0] cnt, input logic hlt);
        logic [5:0] s;
        logic fetch, src, m2r, rw, dmw;
        s     = (st == 3'b010 || st == 3'b011 || st == 3'b100) ? stat_of(o) : 6'b0;
        fetch = (st == 3'b000);
        src   = (st == 3'b010) && (o == BEQ) && z;
        m2r   = (o == LW) && (st == 3'b011 || st == 3'b100);
        rw    = (st == 3'b100);
        dmw   = (st == 3'b011) && (o == SW);
        return {st, fetch, fetch, last, src, s[5], m2r, rw, dmw, s[4], s[3], s[2:0], hlt, cnt};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {State, IRWre, InsMemRW, PCWre, PCSrc, ALUSrcB, ALUM2Reg, RegWre,
                DataMemRW, ExtSel, RegOut, ALUOp, Halted, RetireCnt};
    endfunction

    // Runs one instruction from IF (entered at a negedge), checking every
    // cycle. zexe>=0 forces zero in EXE; stop truncates the run early.
    task automatic run_instr(input logic [5:0] opc, input int zexe, input int stop);
        int n, lim;
        logic [VW-1:0] e, o;
        n   = ncyc(opc);
        lim = (stop < n) ? stop : n;
        for (int k = 0; k < lim; k++) begin
            op   = (k == 0) ? 6'($urandom) : opc;
            zero = (k == 2 && zexe >= 0) ? zexe[0] : 1'($urandom);
            #2;
            e = model(st_of(opc, k), opc, zero, (k == n - 1), exp_cnt[CW-1:0], 1'b0);
            o = obs();
            vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL instr op=%b cyc=%0d got=%h exp=%h", opc, k, o, e);
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        if (lim == n) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] tbl [11];
        tbl = '{ADD, ADDI, SUB, ORI, ANDO, ORO, MOVE, SW, LW, BEQ, BAD};
        return tbl[$urandom_range(10, 0)];
    endfunction

    task automatic test_reset();
        logic [VW-1:0] e;
        Reset = 1'b1;
        op    = 6'($urandom);
        #3;
        e = model(3'b000, op, zero, 1'b0, '0, 1'b0);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("FAIL reset got=%h exp=%h", obs(), e);
        end
        @(posedge CLK);
        #2;
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), e);
        end
        @(negedge CLK);
        Reset   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_alu();
        logic [5:0] alu [7];
        alu = '{ADD, ADDI, SUB, ORI, ANDO, ORO, MOVE};
        run_instr(ADD, -1, 99);
        #1;
        vecs++;
        if (RetireCnt !== 1) begin
            errs++;
            $display("FAIL add_retire got=%0d exp=1", RetireCnt);
        end
        for (int i = 0; i < 7; i++) run_instr(alu[i], -1, 99);
        for (int i = 0; i < 4; i++) run_instr(alu[$urandom_range(6, 0)], -1, 99);
    endtask

    task automatic test_mem();
        run_instr(LW, -1, 99);
        run_instr(SW, -1, 99);
        run_instr(LW, -1, 99);
        run_instr(SW, -1, 99);
    endtask

    task automatic test_beq();
        run_instr(BEQ, 1, 99);
        run_instr(BEQ, 0, 99);
        for (int i = 0; i < 4; i++) run_instr(BEQ, -1, 99);
    endtask

    task automatic test_unknown_halt();
        logic [VW-1:0] e;
        run_instr(BAD, -1, 99);
        run_instr(ADD, -1, 99);
        run_instr(HALT, -1, 2);
        for (int k = 0; k < 12; k++) begin
            op   = rand_op();
            zero = 1'($urandom);
            #2;
            e = model(3'b111, HALT, zero, 1'b0, exp_cnt[CW-1:0], 1'b1);
            vecs++;
            if (obs() !== e) begin
                errs++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", k, obs(), e);
            end
            @(negedge CLK);
        end
        Reset = 1'b1;
        #2;
        e = model(3'b000, op, zero, 1'b0, '0, 1'b0);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("FAIL halt_exit got=%h exp=%h", obs(), e);
        end
        @(negedge CLK);
        Reset   = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) run_instr(rand_op(), -1, 99);
        #1;
        vecs++;
        if (RetireCnt !== 4'd1 || exp_cnt != 1) begin
            errs++;
            $display("FAIL wrap got=%0d exp=1", RetireCnt);
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [VW-1:0] e;
        run_instr(ADD, -1, 99);
        run_instr(LW, -1, 3);
        zero = 1'($urandom);
        #2;
        e = model(3'b011, LW, zero, 1'b0, exp_cnt[CW-1:0], 1'b0);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("FAIL lw_mem got=%h exp=%h", obs(), e);
        end
        Reset = 1'b1;
        #1;
        e = model(3'b000, LW, zero, 1'b0, '0, 1'b0);
        vecs++;
        if (obs() !== e) begin
            errs++;
            $display("FAIL reset_async got=%h exp=%h", obs(), e);
        end
        @(posedge CLK);
        #1;
        vecs++;
        if (RegWre !== 1'b0 || State !== 3'b000 || RetireCnt !== '0) begin
            errs++;
            $display("FAIL reset_lw_hold got=%b/%b/%0d exp=0/000/0", RegWre, State, RetireCnt);
        end
        @(negedge CLK);
        Reset   = 1'b0;
        exp_cnt = 0;
        run_instr(ADD, -1, 99);
        #1;
        vecs++;
        if (RetireCnt !== 4'd1) begin
            errs++;
            $display("FAIL post_reset_retire got=%0d exp=1", RetireCnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_beq();
        test_unknown_halt();
        test_wrap();
        test_reset_mid_lw();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
